// File: rtl/vga_text_buffer.sv
// vga_text_buffer: character buffer sitting upstream of the VGA text renderer.
// Accepts codes over a valid/ready stream, keeps a cursor, and stores codes
// in a ROWS x COLS character RAM with a registered, read-first read port.
// Optional feature macro: TXT_SCROLL_EN (scroll up at the bottom row instead
// of wrapping the cursor back to the top).
module vga_text_buffer #(
  parameter int COLS  = 70,
  parameter int ROWS  = 8,
  parameter int CW    = 8,
  parameter int ROW_W = $clog2(ROWS),
  parameter int COL_W = $clog2(COLS)
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             ch_valid,
  output logic             ch_ready,
  input  logic [CW-1:0]    ch_data,
  input  logic [ROW_W-1:0] rd_row,
  input  logic [COL_W-1:0] rd_col,
  output logic [CW-1:0]    rd_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [CW-1:0]    BLANK     = {CW{1'b1}};
  localparam logic [CW-1:0]    NEWLINE   = CW'('h80);
  localparam logic [CW-1:0]    BACKSPACE = CW'('h81);
  localparam logic [CW-1:0]    CLEAR     = CW'('h82);
  localparam logic [ROW_W:0]   ROWS_X    = (ROW_W+1)'(ROWS);
  localparam logic [COL_W:0]   COLS_X    = (COL_W+1)'(COLS);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
  localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;

  // Logical-to-physical row mapping; explicit wrap so ROWS need not be a power of 2.
  function automatic logic [ROW_W-1:0] phys_of(input logic [ROW_W-1:0] lrow,
                                               input logic [ROW_W-1:0] top);
    logic [ROW_W:0] s;
    s = {1'b0, lrow} + {1'b0, top};
    if (s >= ROWS_X) s = s - ROWS_X;
    return s[ROW_W-1:0];
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [ROW_W-1:0] prow,
                                            input logic [COL_W-1:0] col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  state_t           r_state;
  logic [ROW_W-1:0] r_cur_row;
  logic [COL_W-1:0] r_cur_col;
  logic [ROW_W-1:0] r_top;
  logic [ROW_W-1:0] r_clr_row;
  logic [AW-1:0]    r_cnt;
  logic [CW-1:0]    r_rd_data;
  logic [CW-1:0]    r_mem [DEPTH];

  state_t           w_state_nxt;
  logic [ROW_W-1:0] w_row_nxt;
  logic [COL_W-1:0] w_col_nxt;
  logic [ROW_W-1:0] w_top_nxt;
  logic [ROW_W-1:0] w_clr_row_nxt;
  logic [AW-1:0]    w_cnt_nxt;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [CW-1:0]    w_wdata;
  logic             w_advance;
  logic [ROW_W-1:0] w_phys_cur;
  logic [ROW_W-1:0] w_phys_prev;
  logic [ROW_W-1:0] w_rd_phys;
  logic [AW-1:0]    w_raddr;
  logic             w_rd_oob;

  assign w_phys_cur  = phys_of(r_cur_row, r_top);
  assign w_phys_prev = phys_of(r_cur_row - 1'b1, r_top);
  assign w_rd_phys   = phys_of(rd_row, r_top);
  assign w_raddr     = addr_of(w_rd_phys, rd_col);
  assign w_rd_oob    = ({1'b0, rd_row} >= ROWS_X) || ({1'b0, rd_col} >= COLS_X);

  // Next-state, cursor update and RAM write request for the clear/idle FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch; blocking '=' is correct here.
    w_state_nxt   = r_state;
    w_row_nxt     = r_cur_row;
    w_col_nxt     = r_cur_col;
    w_top_nxt     = r_top;
    w_clr_row_nxt = r_clr_row;
    w_cnt_nxt     = r_cnt;
    w_we          = 1'b0;
    w_waddr       = r_cnt;
    w_wdata       = BLANK;
    w_advance     = 1'b0;

    case (r_state)
      CLR_ALL: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      CLR_ROW: begin
        w_we    = 1'b1;
        w_waddr = addr_of(r_clr_row, r_cnt[COL_W-1:0]);
        if (r_cnt[COL_W-1:0] == LAST_COL) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      IDLE: begin
        if (ch_valid) begin
          case (ch_data)
            NEWLINE: begin
              w_col_nxt = '0;
              w_advance = 1'b1;
            end
            BACKSPACE: begin
              if (r_cur_col != '0) begin
                w_col_nxt = r_cur_col - 1'b1;
                w_we      = 1'b1;
                w_waddr   = addr_of(w_phys_cur, r_cur_col - 1'b1);
              end else if (r_cur_row != '0) begin
                w_row_nxt = r_cur_row - 1'b1;
                w_col_nxt = LAST_COL;
                w_we      = 1'b1;
                w_waddr   = addr_of(w_phys_prev, LAST_COL);
              end
            end
            CLEAR: begin
              w_row_nxt   = '0;
              w_col_nxt   = '0;
              w_top_nxt   = '0;
              w_cnt_nxt   = '0;
              w_state_nxt = CLR_ALL;
            end
            default: begin
              w_we    = 1'b1;
              w_waddr = addr_of(w_phys_cur, r_cur_col);
              w_wdata = ch_data;
              if (r_cur_col == LAST_COL) begin
                w_col_nxt = '0;
                w_advance = 1'b1;
              end else begin
                w_col_nxt = r_cur_col + 1'b1;
              end
            end
          endcase
        end
      end
      default: w_state_nxt = CLR_ALL;
    endcase

    // Row advance: step down, or at the bottom scroll/wrap and blank a row.
    if (w_advance) begin
      if (r_cur_row != LAST_ROW) begin
        w_row_nxt = r_cur_row + 1'b1;
      end else begin
        w_state_nxt = CLR_ROW;
        w_cnt_nxt   = '0;
`ifdef TXT_SCROLL_EN
        w_top_nxt     = phys_of(ROW_W'(1), r_top);
        w_clr_row_nxt = r_top;
`else
        w_row_nxt     = '0;
        w_clr_row_nxt = '0;
`endif
      end
    end
  end

  // FSM state, cursor and clear-sequence registers.
  always_ff @(posedge vga_clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // together from values sampled at the same edge.
    if (reset) begin
      r_state   <= CLR_ALL;
      r_cur_row <= '0;
      r_cur_col <= '0;
      r_top     <= '0;
      r_clr_row <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_row <= w_row_nxt;
      r_cur_col <= w_col_nxt;
      r_top     <= w_top_nxt;
      r_clr_row <= w_clr_row_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Character RAM write port.
  always_ff @(posedge vga_clk) begin
    // NOTE: the RAM has no reset; the CLR_ALL sweep after reset blanks it,
    // which keeps it mappable to block RAM.
    if (w_we && !reset) r_mem[w_waddr] <= w_wdata;
  end

  // Registered read port; same-cycle write to the same address returns old data.
  always_ff @(posedge vga_clk) begin
    if (reset)         r_rd_data <= BLANK;
    else if (w_rd_oob) r_rd_data <= BLANK;
    else               r_rd_data <= r_mem[w_raddr];
  end

  assign ch_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  assign rd_data  = r_rd_data;
  assign cur_row  = r_cur_row;
  assign cur_col  = r_cur_col;

endmodule

// File: tb/tb_vga_text_buffer.sv
// tb_vga_text_buffer: directed self-checking bench for vga_text_buffer.
// Covers whichever row-advance variant is built (TXT_SCROLL_EN or not).
module tb_vga_text_buffer;

  logic       vga_clk  = 1'b0;
  logic       reset    = 1'b1;
  logic       ch_valid = 1'b0;
  logic [7:0] ch_data  = '0;
  logic [2:0] rd_row   = '0;
  logic [6:0] rd_col   = '0;
  logic       ch_ready;
  logic [7:0] rd_data;
  logic [2:0] cur_row;
  logic [6:0] cur_col;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 vga_clk = ~vga_clk;

  vga_text_buffer dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .ch_valid(ch_valid),
    .ch_ready(ch_ready),
    .ch_data (ch_data),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_data (rd_data),
    .cur_row (cur_row),
    .cur_col (cur_col),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd(input int r, input int c, output logic [7:0] d);
    rd_row = r[2:0];
    rd_col = c[6:0];
    @(negedge vga_clk);
    d = rd_data;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ch_ready && n < 3000) begin
      @(negedge vga_clk);
      n++;
    end
    if (!ch_ready) check("ready_timeout", {31'b0, ch_ready}, 1);
  endtask

  task automatic send(input logic [7:0] code);
    wait_ready();
    ch_valid = 1'b1;
    ch_data  = code;
    @(negedge vga_clk);
    ch_valid = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      @(negedge vga_clk);
    end
  endtask

  task automatic check_cur(input string tag, input int r, input int c);
    check({tag, "_row"}, cur_row, r);
    check({tag, "_col"}, cur_col, c);
  endtask

  task automatic check_row_blank(input string tag, input int r);
    int bad = 0;
    logic [7:0] d;
    for (int c = 0; c < 70; c++) begin
      rd(r, c, d);
      if (d !== 8'hFF) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic check_all_blank(input string tag);
    int bad = 0;
    logic [7:0] d;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 70; c++) begin
        rd(r, c, d);
        if (d !== 8'hFF) bad++;
      end
    check(tag, bad, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int miss;
    logic [7:0] d;

    // T1: reset state, with ch_valid held high during reset
    ch_valid = 1'b1;
    ch_data  = 8'h07;
    repeat (3) @(negedge vga_clk);
    check("rst_rd_data", rd_data, 8'hFF);
    check("rst_busy", busy, 1);
    check("rst_ready", ch_ready, 0);
    check_cur("rst_cur", 0, 0);
    reset    = 1'b0;
    ch_valid = 1'b0;
    busy_len(n);
    check("t1_busy_cycles", n, 560);
    check("t1_ready", ch_ready, 1);
    check_cur("t1_cur_no_write", 0, 0);
    check_all_blank("t1_all_blank");

    // T2: 0..9 back to back with ch_valid held high
    wait_ready();
    miss = 0;
    ch_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ch_data = 8'(i);
      if (!ch_ready) miss++;
      @(negedge vga_clk);
    end
    ch_valid = 1'b0;
    check("t2_ready_held", miss, 0);
    check_cur("t2_cur", 0, 10);
    for (int i = 0; i < 10; i++) begin
      rd(0, i, d);
      check($sformatf("t2_rd_0_%0d", i), d, i);
    end

    // T6a: CLEAR mid-text, then BACKSPACE at (0,0) is a no-op
    send(8'h82);
    busy_len(n);
    check("clear_busy_cycles", n, 560);
    check_cur("clear_cur", 0, 0);
    check_all_blank("clear_all_blank");
    send(8'h81);
    check_cur("bs_origin_cur", 0, 0);
    check("bs_origin_ready", ch_ready, 1);
    rd(0, 0, d);
    check("bs_origin_rd", d, 8'hFF);

    // T3: full row of 8'h05, line wrap, backspace across rows
    for (int i = 0; i < 70; i++) send(8'h05);
    check_cur("t3_wrap_cur", 1, 0);
    rd(0, 69, d);
    check("t3_rd_0_69", d, 8'h05);
    rd(0, 0, d);
    check("t3_rd_0_0", d, 8'h05);
    send(8'h81);
    check_cur("t3_bs_cur", 0, 69);
    rd(0, 69, d);
    check("t3_bs_rd_0_69", d, 8'hFF);
    rd(0, 68, d);
    check("t3_bs_rd_0_68", d, 8'h05);
    send(8'h05);
    send(8'h09);
    check_cur("t3_row1_cur", 1, 1);
    rd(1, 0, d);
    check("t3_rd_1_0", d, 8'h09);
    rd(0, 70, d);
    check("oob_col_70", d, 8'hFF);
    rd(0, 127, d);
    check("oob_col_127", d, 8'hFF);
    send(8'h81);
    check_cur("t3_bs2_cur", 1, 0);
    rd(1, 0, d);
    check("t3_bs2_rd_1_0", d, 8'hFF);

    // T4/T5: fill to the bottom row, then NEWLINE at the bottom
    send(8'h82);
    send(8'h01);
    for (int i = 0; i < 7; i++) send(8'h80);
    send(8'h03);
    check_cur("bottom_cur", 7, 1);
    send(8'h80);
    busy_len(n);
    check("clr_row_cycles", n, 70);
`ifdef TXT_SCROLL_EN
    check_cur("t4_cur", 7, 0);
    rd(6, 0, d);
    check("t4_rd_6_0", d, 8'h03);
    check_row_blank("t4_row7_blank", 7);
    rd(0, 0, d);
    check("t4_rd_0_0_scrolled", d, 8'hFF);
`else
    check_cur("t5_cur", 0, 0);
    check_row_blank("t5_row0_blank", 0);
    rd(7, 0, d);
    check("t5_rd_7_0", d, 8'h03);
    rd(1, 0, d);
    check("t5_rd_1_0", d, 8'hFF);
`endif

    // T6b: reset asserted during CLR_ROW, with ch_valid high
    for (int i = 0; i < 9 && !busy; i++) send(8'h80);
    check("t6_clr_row_entered", busy, 1);
    repeat (5) @(negedge vga_clk);
    check("t6_mid_clr_row_busy", busy, 1);
    reset    = 1'b1;
    ch_valid = 1'b1;
    ch_data  = 8'h41;
    repeat (2) @(negedge vga_clk);
    check_cur("t6_rst_cur", 0, 0);
    check("t6_rst_ready", ch_ready, 0);
    reset    = 1'b0;
    ch_valid = 1'b0;
    busy_len(n);
    check("t6_busy_cycles", n, 560);
    check_cur("t6_cur", 0, 0);
    check_all_blank("t6_all_blank");
    send(8'h07);
    rd(0, 0, d);
    check("t6_rd_0_0_after", d, 8'h07);
    check_cur("t6_cur_after", 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
